// File: rtl/ahb_addr_parity_checker.sv
// AHB-lite slave-side address parity filter.
// Recomputes the 4-bit interleaved HADDR parity and fails mismatching transfers.
//
// Ports:
//   s_clk_i, s_resetn_i : clock, synchronous active-low reset
//   s_h*_i / s_h*_o     : upstream AHB-lite slave port (address phase in, data phase out)
//   m_h*_o / m_h*_i     : downstream AHB-lite master port towards the protected slave
//   err_clear_i         : clears captured address, sticky flag and counter
//   err_valid_o         : sticky flag, set on the first uncleared parity error
//   err_addr_o          : address of the first uncleared faulty transfer
//   err_count_o         : saturating count of faulty transfers
module ahb_addr_parity_checker #(
   parameter int CNT_WIDTH = 8,
   parameter bit CHECK_EN  = 1'b1
) (
   input  logic                 s_clk_i,
   input  logic                 s_resetn_i,
   input  logic                 s_hsel_i,
   input  logic [1:0]           s_htrans_i,
   input  logic [31:0]          s_haddr_i,
   input  logic [3:0]           s_hparity_i,
   input  logic                 s_hwrite_i,
   input  logic [2:0]           s_hsize_i,
   input  logic [31:0]          s_hwdata_i,
   input  logic                 s_hready_i,
   output logic [31:0]          s_hrdata_o,
   output logic                 s_hreadyout_o,
   output logic                 s_hresp_o,
   output logic                 m_hsel_o,
   output logic [1:0]           m_htrans_o,
   output logic [31:0]          m_haddr_o,
   output logic                 m_hwrite_o,
   output logic [2:0]           m_hsize_o,
   output logic [31:0]          m_hwdata_o,
   output logic                 m_hready_o,
   input  logic [31:0]          m_hrdata_i,
   input  logic                 m_hreadyout_i,
   input  logic                 m_hresp_i,
   input  logic                 err_clear_i,
   output logic                 err_valid_o,
   output logic [31:0]          err_addr_o,
   output logic [CNT_WIDTH-1:0] err_count_o
);

   typedef enum logic [1:0] {
      PASS = 2'd0,
      ERR1 = 2'd1,
      ERR2 = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // Bit p of the parity covers haddr[p], haddr[p+4], ... haddr[p+28],
   // which is simply the XOR of the eight address nibbles.
   function automatic logic [3:0] addr_parity(input logic [31:0] a);
      logic [3:0] p;
      p = 4'h0;
      for (int k = 0; k < 8; k++) begin
         p = p ^ a[4*k +: 4];
      end
      return p;
   endfunction

   state_t                state_q;
   logic                  rsp_err_q;
   logic                  rsp_wait_q;
   logic                  err_valid_q;
   logic [31:0]           err_addr_q;
   logic [CNT_WIDTH-1:0]  err_count_q;

   logic                  accept;
   logic                  par_bad;
   logic                  bad;

   assign accept  = s_hsel_i & s_htrans_i[1] & s_hready_i;
   assign par_bad = addr_parity(s_haddr_i) != s_hparity_i;
   assign bad     = accept & CHECK_EN & par_bad;

   // Address phase: forward everything, but turn a faulty transfer into
   // an unselected IDLE so the downstream slave never acts on it.
   assign m_hsel_o   = s_hsel_i & ~bad;
   assign m_htrans_o = bad ? 2'b00 : s_htrans_i;
   assign m_haddr_o  = s_haddr_i;
   assign m_hwrite_o = s_hwrite_i;
   assign m_hsize_o  = s_hsize_i;
   assign m_hwdata_o = s_hwdata_i;
   assign m_hready_o = s_hready_i;

   // Data phase: mirror downstream unless an error response is in flight.
   always_comb begin
      s_hrdata_o    = m_hrdata_i;
      s_hreadyout_o = m_hreadyout_i;
      s_hresp_o     = m_hresp_i;
      if (rsp_err_q) begin
         s_hrdata_o    = 32'h0;
         s_hreadyout_o = ~rsp_wait_q;
         s_hresp_o     = 1'b1;
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (!s_resetn_i) begin
         state_q    <= PASS;
         rsp_err_q  <= 1'b0;
         rsp_wait_q <= 1'b0;
      end else begin
         unique case (state_q)
            PASS: begin
               if (bad) begin
                  state_q    <= ERR1;
                  rsp_err_q  <= 1'b1;
                  rsp_wait_q <= 1'b1;
               end
            end
            ERR1: begin
               state_q    <= ERR2;
               rsp_err_q  <= 1'b1;
               rsp_wait_q <= 1'b0;
            end
            ERR2: begin
               // HREADY is high here, so a new address phase may be accepted.
               if (bad) begin
                  state_q    <= ERR1;
                  rsp_err_q  <= 1'b1;
                  rsp_wait_q <= 1'b1;
               end else begin
                  state_q    <= PASS;
                  rsp_err_q  <= 1'b0;
                  rsp_wait_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= PASS;
               rsp_err_q  <= 1'b0;
               rsp_wait_q <= 1'b0;
            end
         endcase
      end
   end

   // A fault in the same cycle as a clear wins: it becomes the first
   // captured error of the new reporting window.
   always_ff @(posedge s_clk_i) begin
      if (!s_resetn_i) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= 32'h0;
         err_count_q <= '0;
      end else if (bad) begin
         err_valid_q <= 1'b1;
         if (!err_valid_q || err_clear_i) begin
            err_addr_q <= s_haddr_i;
         end
         if (err_clear_i) begin
            err_count_q <= CNT_ONE;
         end else if (err_count_q != CNT_MAX) begin
            err_count_q <= err_count_q + CNT_ONE;
         end
      end else if (err_clear_i) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= 32'h0;
         err_count_q <= '0;
      end
   end

   assign err_valid_o = err_valid_q;
   assign err_addr_o  = err_addr_q;
   assign err_count_o = err_count_q;

endmodule

// File: tb/tb_ahb_addr_parity_checker.sv
// Scoreboard bench for ahb_addr_parity_checker.
// Directed per-cycle vectors; a negedge monitor pops and compares.
module tb_ahb_addr_parity_checker;

   typedef struct packed {
      logic        rstn;
      logic        clr;
      logic        sel;
      logic [1:0]  tr;
      logic        hrdy;
      logic [31:0] addr;
      logic [3:0]  par;
      logic        wr;
      logic [31:0] mrd;
      logic        mro;
      logic        mrs;
   } stim_t;

   typedef struct packed {
      logic        ro;
      logic        rs;
      logic [31:0] rd;
      logic        msel;
      logic [1:0]  mtr;
      logic        ev;
      logic [31:0] ea;
      logic [1:0]  ec;
   } exp_t;

   typedef struct packed {
      exp_t        e;
      logic [31:0] maddr;
      logic        mrdy;
      logic        mwr;
      logic [31:0] mwd;
   } sb_t;

   logic        clk;
   logic        rstn;
   logic        hsel;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic [3:0]  hpar;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic [31:0] s_hrdata;
   logic        s_hreadyout;
   logic        s_hresp;
   logic        m_hsel;
   logic [1:0]  m_htrans;
   logic [31:0] m_haddr;
   logic        m_hwrite;
   logic [2:0]  m_hsize;
   logic [31:0] m_hwdata;
   logic        m_hready;
   logic [31:0] m_hrdata;
   logic        m_hreadyout;
   logic        m_hresp;
   logic        clr;
   logic        err_valid;
   logic [31:0] err_addr;
   logic [1:0]  err_count;

   int errors = 0;
   int checks = 0;

   sb_t   sb_q[$];
   string nm_q[$];

   ahb_addr_parity_checker #(
      .CNT_WIDTH(2),
      .CHECK_EN (1'b1)
   ) dut (
      .s_clk_i      (clk),
      .s_resetn_i   (rstn),
      .s_hsel_i     (hsel),
      .s_htrans_i   (htrans),
      .s_haddr_i    (haddr),
      .s_hparity_i  (hpar),
      .s_hwrite_i   (hwrite),
      .s_hsize_i    (hsize),
      .s_hwdata_i   (hwdata),
      .s_hready_i   (hready),
      .s_hrdata_o   (s_hrdata),
      .s_hreadyout_o(s_hreadyout),
      .s_hresp_o    (s_hresp),
      .m_hsel_o     (m_hsel),
      .m_htrans_o   (m_htrans),
      .m_haddr_o    (m_haddr),
      .m_hwrite_o   (m_hwrite),
      .m_hsize_o    (m_hsize),
      .m_hwdata_o   (m_hwdata),
      .m_hready_o   (m_hready),
      .m_hrdata_i   (m_hrdata),
      .m_hreadyout_i(m_hreadyout),
      .m_hresp_i    (m_hresp),
      .err_clear_i  (clr),
      .err_valid_o  (err_valid),
      .err_addr_o   (err_addr),
      .err_count_o  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t S(
      input logic rs, input logic cl, input logic se,
      input logic [1:0] t, input logic hr,
      input logic [31:0] a, input logic [3:0] p,
      input logic w, input logic [31:0] d,
      input logic ro, input logic rp);
      stim_t s;
      s.rstn = rs; s.clr = cl; s.sel = se; s.tr = t;
      s.hrdy = hr; s.addr = a; s.par = p; s.wr = w;
      s.mrd = d; s.mro = ro; s.mrs = rp;
      return s;
   endfunction

   function automatic exp_t E(
      input logic ro, input logic rp, input logic [31:0] d,
      input logic ms, input logic [1:0] mt,
      input logic v, input logic [31:0] a, input logic [1:0] c);
      exp_t e;
      e.ro = ro; e.rs = rp; e.rd = d; e.msel = ms;
      e.mtr = mt; e.ev = v; e.ea = a; e.ec = c;
      return e;
   endfunction

   task automatic step(input string nm, input bit chk,
                       input stim_t s, input exp_t e);
      sb_t x;
      @(posedge clk);
      #1;
      rstn        = s.rstn;
      clr         = s.clr;
      hsel        = s.sel;
      htrans      = s.tr;
      hready      = s.hrdy;
      haddr       = s.addr;
      hpar        = s.par;
      hwrite      = s.wr;
      hsize       = 3'b010;
      hwdata      = ~s.addr;
      m_hrdata    = s.mrd;
      m_hreadyout = s.mro;
      m_hresp     = s.mrs;
      if (chk) begin
         x.e     = e;
         x.maddr = s.addr;
         x.mrdy  = s.hrdy;
         x.mwr   = s.wr;
         x.mwd   = ~s.addr;
         sb_q.push_back(x);
         nm_q.push_back(nm);
      end
   endtask

   task automatic cmp(input string nm, input string f,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_t   x;
         string n;
         x = sb_q.pop_front();
         n = nm_q.pop_front();
         cmp(n, "hreadyout", 32'(s_hreadyout), 32'(x.e.ro));
         cmp(n, "hresp", 32'(s_hresp), 32'(x.e.rs));
         cmp(n, "hrdata", s_hrdata, x.e.rd);
         cmp(n, "m_hsel", 32'(m_hsel), 32'(x.e.msel));
         cmp(n, "m_htrans", 32'(m_htrans), 32'(x.e.mtr));
         cmp(n, "m_haddr", m_haddr, x.maddr);
         cmp(n, "m_hready", 32'(m_hready), 32'(x.mrdy));
         cmp(n, "m_hwrite", 32'(m_hwrite), 32'(x.mwr));
         cmp(n, "m_hwdata", m_hwdata, x.mwd);
         cmp(n, "m_hsize", 32'(m_hsize), 32'h2);
         cmp(n, "err_valid", 32'(err_valid), 32'(x.e.ev));
         cmp(n, "err_addr", err_addr, x.e.ea);
         cmp(n, "err_count", 32'(err_count), 32'(x.e.ec));
      end
   end

   initial begin
      int budget;
      rstn = 1'b0; clr = 1'b0; hsel = 1'b0; htrans = 2'b00;
      haddr = '0; hpar = '0; hwrite = 1'b0; hsize = 3'b010;
      hwdata = '0; hready = 1'b1; m_hrdata = '0;
      m_hreadyout = 1'b1; m_hresp = 1'b0;

      step("rst0", 0, S(0,0,0,0,1,0,0,0,0,1,0), E(0,0,0,0,0,0,0,0));
      step("rst1", 1, S(0,0,0,0,1,0,0,0,32'h1111,1,0),
           E(1,0,32'h1111,0,0,0,0,0));
      step("good_rd_a", 1, S(1,0,1,2,1,32'h80000000,4'h8,0,32'h2222,1,0),
           E(1,0,32'h2222,1,2,0,0,0));
      step("wait_mirror", 1, S(1,0,0,0,0,0,0,0,32'hCAFEF00D,0,0),
           E(0,0,32'hCAFEF00D,0,0,0,0,0));
      step("bad_wr_a", 1, S(1,0,1,2,1,32'h10000004,4'h0,1,32'h3333,1,0),
           E(1,0,32'h3333,0,0,0,0,0));
      step("bad_wr_e1", 1, S(1,0,0,0,0,0,0,0,32'h4444,1,0),
           E(0,1,0,0,0,1,32'h10000004,1));
      step("bad_wr_e2", 1, S(1,0,0,0,1,0,0,0,32'h4444,1,0),
           E(1,1,0,0,0,1,32'h10000004,1));
      step("pass_after", 1, S(1,0,0,0,1,0,0,0,32'h5555,1,0),
           E(1,0,32'h5555,0,0,1,32'h10000004,1));
      step("bad2_a", 1, S(1,0,1,2,1,32'h20000000,4'h0,0,32'h6666,1,0),
           E(1,0,32'h6666,0,0,1,32'h10000004,1));
      step("bad2_e1", 1, S(1,0,0,0,0,0,0,0,32'h6666,1,0),
           E(0,1,0,0,0,1,32'h10000004,2));
      step("good_in_e2", 1, S(1,0,1,2,1,32'h80000000,4'h8,0,32'h7777,1,0),
           E(1,1,0,1,2,1,32'h10000004,2));
      step("good_data", 1, S(1,0,0,0,1,0,0,0,32'h8888,1,0),
           E(1,0,32'h8888,0,0,1,32'h10000004,2));
      step("bad3_a", 1, S(1,0,1,3,1,32'h1,4'h0,0,32'h9999,1,0),
           E(1,0,32'h9999,0,0,1,32'h10000004,2));
      step("bad3_e1", 1, S(1,0,0,0,0,0,0,0,32'h9999,1,0),
           E(0,1,0,0,0,1,32'h10000004,3));
      step("bad4_in_e2", 1, S(1,0,1,2,1,32'h2,4'h0,1,32'h9999,1,0),
           E(1,1,0,0,0,1,32'h10000004,3));
      step("bad4_e1", 1, S(1,0,0,0,0,0,0,0,32'h9999,1,0),
           E(0,1,0,0,0,1,32'h10000004,3));
      step("bad5_in_e2", 1, S(1,0,1,2,1,32'h4,4'h0,0,32'h9999,1,0),
           E(1,1,0,0,0,1,32'h10000004,3));
      step("bad5_e1", 1, S(1,0,0,0,0,0,0,0,32'h9999,1,0),
           E(0,1,0,0,0,1,32'h10000004,3));
      step("bad5_e2", 1, S(1,0,0,0,1,0,0,0,32'h9999,1,0),
           E(1,1,0,0,0,1,32'h10000004,3));
      step("pass_hresp", 1, S(1,0,0,0,1,0,0,0,32'hAAAA,1,1),
           E(1,1,32'hAAAA,0,0,1,32'h10000004,3));
      step("idle_nochk", 1, S(1,0,1,0,1,32'h10000004,4'h0,0,32'hBBBB,1,0),
           E(1,0,32'hBBBB,1,0,1,32'h10000004,3));
      step("busy_nochk", 1, S(1,0,1,1,1,32'h1,4'h0,0,32'hBBBB,1,0),
           E(1,0,32'hBBBB,1,1,1,32'h10000004,3));
      step("nosel_nochk", 1, S(1,0,0,2,1,32'h1,4'h0,0,32'hBBBB,1,0),
           E(1,0,32'hBBBB,0,2,1,32'h10000004,3));
      step("nordy_nochk", 1, S(1,0,1,2,0,32'h1,4'h0,0,32'hBBBB,0,0),
           E(0,0,32'hBBBB,1,2,1,32'h10000004,3));
      step("clr_bad", 1, S(1,1,1,2,1,32'h80000010,4'h0,0,32'hCCCC,1,0),
           E(1,0,32'hCCCC,0,0,1,32'h10000004,3));
      step("clr_e1", 1, S(1,0,0,0,0,0,0,0,32'hCCCC,1,0),
           E(0,1,0,0,0,1,32'h80000010,1));
      step("clr_e2", 1, S(1,1,0,0,1,0,0,0,32'hCCCC,1,0),
           E(1,1,0,0,0,1,32'h80000010,1));
      step("after_clr", 1, S(1,0,0,0,1,0,0,0,32'hDDDD,1,0),
           E(1,0,32'hDDDD,0,0,0,0,0));
      step("bad6_a", 1, S(1,0,1,2,1,32'h80000000,4'h0,0,32'hEEEE,1,0),
           E(1,0,32'hEEEE,0,0,0,0,0));
      step("rst_in_e1", 1, S(0,0,0,0,0,0,0,0,32'h1234,0,0),
           E(0,1,0,0,0,1,32'h80000000,1));
      step("post_rst", 1, S(1,0,0,0,1,0,0,0,32'h5678,0,0),
           E(0,0,32'h5678,0,0,0,0,0));
      step("final_good", 1, S(1,0,1,2,1,32'h80000000,4'h8,1,32'h9ABC,1,0),
           E(1,0,32'h9ABC,1,2,0,0,0));
      step("idle_tail", 0, S(1,0,0,0,1,0,0,0,0,1,0), E(0,0,0,0,0,0,0,0));

      budget = 0;
      while (sb_q.size() > 0 && budget < 8) begin
         @(negedge clk);
         budget++;
      end
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
